pkt_switch_n: RTL and testbench

PKT_SWITCH_N -- requirements
Module: pkt_switch_n

---
 rtl/pkt_switch_n_if.sv | 27 ++
 rtl/pkt_switch_n.sv | 151 +++++++++++++++
 tb/tb_pkt_switch_n.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pkt_switch_n_if.sv
// Port bundle for pkt_switch_n: per-port input/output packet handshakes and the drop counter.
// master = traffic source/sink side, slave = the switch itself.
interface pkt_switch_n_if #(
  parameter int unsigned N_PORTS = 4,
  parameter int unsigned DATA_W  = 8
);
  localparam int unsigned SRC_W = $clog2(N_PORTS);
  localparam int unsigned PW    = DATA_W + SRC_W + N_PORTS;

  logic [N_PORTS-1:0]    valid_ip;
  logic [N_PORTS*PW-1:0] data_ip;
  logic [N_PORTS-1:0]    suspend_ip;
  logic [N_PORTS-1:0]    valid_op;
  logic [N_PORTS*PW-1:0] data_op;
  logic [N_PORTS-1:0]    suspend_op;
  logic [15:0]           drop_count;

  modport master (
    output valid_ip, data_ip, suspend_op,
    input  suspend_ip, valid_op, data_op, drop_count
  );

  modport slave (
    input  valid_ip, data_ip, suspend_op,
    output suspend_ip, valid_op, data_op, drop_count
  );
endinterface

// File: rtl/pkt_switch_n.sv
// N-port packet switch: one holding register per input, round-robin arbiter and
// packet FIFO per output, multicast via a per-input residual target mask.
module pkt_switch_n #(
  parameter int unsigned N_PORTS = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 4
) (
  input  logic          clk,
  input  logic          reset,
  pkt_switch_n_if.slave bus
);
  localparam int unsigned SRC_W = $clog2(N_PORTS);
  localparam int unsigned PW    = DATA_W + SRC_W + N_PORTS;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = AW + 1;

  // input holding registers
  logic [PW-1:0]      pkt_q  [N_PORTS];
  logic [PW-1:0]      pkt_d  [N_PORTS];
  logic [N_PORTS-1:0] mask_q [N_PORTS];
  logic [N_PORTS-1:0] mask_d [N_PORTS];

  // per-output arbiter and FIFO state
  logic [SRC_W-1:0]   ptr_q  [N_PORTS];
  logic [SRC_W-1:0]   ptr_d  [N_PORTS];
  logic [AW-1:0]      wptr_q [N_PORTS];
  logic [AW-1:0]      wptr_d [N_PORTS];
  logic [AW-1:0]      rptr_q [N_PORTS];
  logic [AW-1:0]      rptr_d [N_PORTS];
  logic [CW-1:0]      cnt_q  [N_PORTS];
  logic [CW-1:0]      cnt_d  [N_PORTS];
  logic [PW-1:0]      mem_q  [N_PORTS][DEPTH];

  logic [15:0]        drop_q, drop_d;
  logic [N_PORTS-1:0] gnt_v;
  logic [SRC_W-1:0]   gnt_src [N_PORTS];
  logic [N_PORTS-1:0] pop;

  assign bus.drop_count = drop_q;

  always_comb begin
    bus.suspend_ip = '0;
    bus.valid_op   = '0;
    bus.data_op    = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      bus.suspend_ip[i] = reset | (mask_q[i] != '0);
      bus.valid_op[i]   = (cnt_q[i] != '0);
      if (cnt_q[i] != '0) begin
        bus.data_op[i*PW +: PW] = mem_q[i][rptr_q[i]];
      end
    end
  end

  // Round-robin search starts at ptr; a full FIFO suppresses the grant regardless of a same-cycle pop.
  always_comb begin
    int unsigned      idx;
    logic [SRC_W-1:0] sel;
    idx = 0;
    sel = '0;
    for (int unsigned j = 0; j < N_PORTS; j++) begin
      gnt_v[j]   = 1'b0;
      gnt_src[j] = '0;
      ptr_d[j]   = ptr_q[j];
      if (cnt_q[j] < CW'(DEPTH)) begin
        for (int unsigned k = 0; k < N_PORTS; k++) begin
          idx = (32'(ptr_q[j]) + k) % N_PORTS;
          sel = SRC_W'(idx);
          if (!gnt_v[j] && mask_q[sel][j]) begin
            gnt_v[j]   = 1'b1;
            gnt_src[j] = sel;
          end
        end
      end
      if (gnt_v[j]) begin
        ptr_d[j] = (gnt_src[j] == SRC_W'(N_PORTS - 1)) ? '0 : gnt_src[j] + SRC_W'(1);
      end
    end
  end

  always_comb begin
    logic [PW-1:0] p;
    p      = '0;
    drop_d = drop_q;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      pkt_d[i]  = pkt_q[i];
      mask_d[i] = mask_q[i];
      for (int unsigned j = 0; j < N_PORTS; j++) begin
        if (gnt_v[j] && (gnt_src[j] == SRC_W'(i))) begin
          mask_d[i][j] = 1'b0;
        end
      end
      // accept only into an empty register; grants never target an empty one, so no overlap
      p = bus.data_ip[i*PW +: PW];
      if (bus.valid_ip[i] && (mask_q[i] == '0)) begin
        p[N_PORTS +: SRC_W] = SRC_W'(i);
        if (p[N_PORTS-1:0] != '0) begin
          pkt_d[i]  = p;
          mask_d[i] = p[N_PORTS-1:0];
        end else if (drop_d != 16'hFFFF) begin
          drop_d = drop_d + 16'd1;
        end
      end
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < N_PORTS; j++) begin
      pop[j]    = (cnt_q[j] != '0) && !bus.suspend_op[j];
      wptr_d[j] = gnt_v[j] ? wptr_q[j] + AW'(1) : wptr_q[j];
      rptr_d[j] = pop[j]   ? rptr_q[j] + AW'(1) : rptr_q[j];
      case ({gnt_v[j], pop[j]})
        2'b10:   cnt_d[j] = cnt_q[j] + CW'(1);
        2'b01:   cnt_d[j] = cnt_q[j] - CW'(1);
        default: cnt_d[j] = cnt_q[j];
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        pkt_q[i]  <= '0;
        mask_q[i] <= '0;
        ptr_q[i]  <= '0;
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      drop_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        pkt_q[i]  <= pkt_d[i];
        mask_q[i] <= mask_d[i];
        ptr_q[i]  <= ptr_d[i];
        wptr_q[i] <= wptr_d[i];
        rptr_q[i] <= rptr_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
      drop_q <= drop_d;
    end
  end

  // FIFO storage is never observed while empty, so it needs no reset
  always_ff @(posedge clk) begin
    for (int unsigned j = 0; j < N_PORTS; j++) begin
      if (gnt_v[j]) begin
        mem_q[j][wptr_q[j]] <= pkt_q[gnt_src[j]];
      end
    end
  end
endmodule

// File: tb/tb_pkt_switch_n.sv
// Scoreboarded bench for pkt_switch_n: directed scenarios plus random traffic
// checked against per-(source,output) expected-packet queues.
module tb_pkt_switch_n;
  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int SRC_W = 2;
  localparam int PW    = DW + SRC_W + N;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pkt_switch_n_if #(.N_PORTS(N), .DATA_W(DW)) bus ();

  pkt_switch_n #(.N_PORTS(N), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int passes = 0;

  logic [PW-1:0] txq [N][$];
  logic [PW-1:0] pq [N*N][$];
  int            seen0 [$];
  int            pop_cnt [N];
  int            drop_exp;

  function automatic logic [PW-1:0] mk(input logic [7:0] d, input logic [1:0] s, input logic [3:0] t);
    return {d, s, t};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else passes++;
  endtask

  task automatic flush_model();
    for (int i = 0; i < N; i++) begin
      txq[i].delete();
      pop_cnt[i] = 0;
    end
    for (int k = 0; k < N*N; k++) pq[k].delete();
    seen0.delete();
    drop_exp = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    flush_model();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic bit model_idle();
    for (int i = 0; i < N; i++) if (txq[i].size() != 0) return 1'b0;
    for (int k = 0; k < N*N; k++) if (pq[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Reference model of an accepted packet: source rewritten, one copy queued per targeted output.
  task automatic model_accept(input int i, input logic [PW-1:0] p);
    logic [N-1:0] t;
    t = p[N-1:0];
    p[N +: SRC_W] = SRC_W'(i);
    if (t == '0) drop_exp++;
    else for (int j = 0; j < N; j++) if (t[j]) pq[i*N + j].push_back(p);
  endtask

  // Sender: presents the head of each port's queue, holding it until accepted.
  initial begin : driver
    bus.valid_ip = '0;
    bus.data_ip  = '0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (txq[i].size() > 0 && !reset) begin
          bus.valid_ip[i]         = 1'b1;
          bus.data_ip[i*PW +: PW] = txq[i][0];
        end else begin
          bus.valid_ip[i] = 1'b0;
        end
      end
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (bus.valid_ip[i] && !bus.suspend_ip[i] && txq[i].size() > 0) begin
          model_accept(i, txq[i].pop_front());
        end
      end
    end
  end

  // Monitor: every output pop is checked against the scoreboard.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!reset) begin
        for (int j = 0; j < N; j++) begin
          if (bus.valid_op[j] && !bus.suspend_op[j]) begin
            logic [PW-1:0]    p;
            logic [SRC_W-1:0] s;
            logic [PW-1:0]    e;
            int               key;
            p   = bus.data_op[j*PW +: PW];
            s   = p[N +: SRC_W];
            key = int'(s) * N + j;
            pop_cnt[j]++;
            if (j == 0) seen0.push_back(int'(s));
            checks++;
            if (pq[key].size() == 0) begin
              $display("FAIL out%0d_unexpected: got %0h expected no packet", j, p);
            end else begin
              e = pq[key].pop_front();
              if (p !== e) $display("FAIL out%0d_data: got %0h expected %0h", j, p, e);
              else passes++;
            end
          end
        end
      end
    end
  end

  initial begin : main
    logic [N-1:0] tgt;
    int           guard;
    reset          = 1'b1;
    bus.suspend_op = '0;
    flush_model();
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid_op", 32'(bus.valid_op), 32'h0);
    chk("rst_suspend_ip", 32'(bus.suspend_ip), 32'hF);
    chk("rst_data_op", 32'(bus.data_op == '0), 32'h1);
    chk("rst_drop", 32'(bus.drop_count), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("rel_suspend_ip", 32'(bus.suspend_ip), 32'h0);

    // single packet, source field rewritten, two-cycle latency
    txq[0].push_back(mk(8'hA5, 2'd3, 4'b0100));
    @(negedge clk);
    @(negedge clk);
    chk("single_early", 32'(bus.valid_op), 32'h0);
    @(negedge clk);
    chk("single_valid", 32'(bus.valid_op), 32'h4);
    chk("single_data", 32'(bus.data_op[2*PW +: PW]), 32'(mk(8'hA5, 2'd0, 4'b0100)));
    repeat (2) @(negedge clk);

    // broadcast: all outputs in one cycle, input busy for one cycle
    do_reset();
    txq[0].push_back(mk(8'h3C, 2'd0, 4'hF));
    @(negedge clk);
    @(negedge clk);
    chk("bcast_susp_hi", 32'(bus.suspend_ip[0]), 32'h1);
    @(negedge clk);
    chk("bcast_valid", 32'(bus.valid_op), 32'hF);
    chk("bcast_susp_lo", 32'(bus.suspend_ip[0]), 32'h0);
    repeat (2) @(negedge clk);

    // contention on output 0 from a fresh pointer
    do_reset();
    for (int i = 0; i < N; i++) txq[i].push_back(mk(8'(8'h10 + i), 2'd0, 4'b0001));
    repeat (10) @(negedge clk);
    chk("cont_count", 32'(seen0.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("cont_order%0d", k), (k < seen0.size()) ? 32'(seen0[k]) : 32'hFFFF, 32'(k));
    end

    // backpressure on output 1
    do_reset();
    @(posedge clk); #2;
    bus.suspend_op = 4'b0010;
    for (int k = 0; k < 6; k++) txq[0].push_back(mk(8'(8'h60 + k), 2'd0, 4'b0010));
    repeat (20) @(negedge clk);
    chk("bp_pending", 32'(txq[0].size()), 32'd1);
    chk("bp_susp", 32'(bus.suspend_ip[0]), 32'h1);
    chk("bp_valid", 32'(bus.valid_op), 32'h2);
    chk("bp_head", 32'(bus.data_op[1*PW +: PW]), 32'(mk(8'h60, 2'd0, 4'b0010)));
    @(posedge clk); #2;
    bus.suspend_op = '0;
    repeat (30) @(negedge clk);
    chk("bp_delivered", 32'(pop_cnt[1]), 32'd6);
    chk("bp_queue_empty", 32'(pq[1].size()), 32'd0);

    // drops: no output activity, counter advances
    do_reset();
    for (int k = 0; k < 3; k++) txq[3].push_back(mk(8'(8'hD0 + k), 2'd0, 4'b0000));
    guard = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.valid_op != '0) guard++;
    end
    chk("drop_idle", 32'(guard), 32'd0);
    chk("drop_count", 32'(bus.drop_count), 32'd3);

    // reset with packets queued in FIFO 1
    do_reset();
    @(posedge clk); #2;
    bus.suspend_op = 4'b0010;
    txq[2].push_back(mk(8'hEE, 2'd0, 4'b0000));
    txq[0].push_back(mk(8'h71, 2'd0, 4'b0010));
    txq[0].push_back(mk(8'h72, 2'd0, 4'b0010));
    guard = 0;
    while (bus.valid_op[1] !== 1'b1 || txq[0].size() != 0 || pq[1].size() != 2) begin
      @(negedge clk);
      guard++;
      if (guard > 20) break;
    end
    @(negedge clk);
    chk("rm_pre_valid", 32'(bus.valid_op[1]), 32'h1);
    chk("rm_pre_drop", 32'(bus.drop_count), 32'd1);
    @(posedge clk); #2;
    reset = 1'b1;
    flush_model();
    #1;
    chk("rm_valid_op", 32'(bus.valid_op), 32'h0);
    chk("rm_drop", 32'(bus.drop_count), 32'h0);
    chk("rm_suspend", 32'(bus.suspend_ip), 32'hF);
    chk("rm_data_op", 32'(bus.data_op == '0), 32'h1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus.suspend_op = '0;
    #1 chk("rm_rel_susp", 32'(bus.suspend_ip), 32'h0);
    txq[1].push_back(mk(8'h99, 2'd2, 4'b0010));
    repeat (6) @(negedge clk);
    chk("rm_resume", 32'(pop_cnt[1]), 32'd1);

    // random traffic
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #2;
      bus.suspend_op = 4'($urandom) & 4'($urandom);
      for (int i = 0; i < N; i++) begin
        if (txq[i].size() < 2 && $urandom_range(0, 2) == 0) begin
          tgt = 4'($urandom);
          txq[i].push_back(mk(8'($urandom), 2'($urandom), tgt));
        end
      end
    end
    @(posedge clk); #2;
    bus.suspend_op = '0;
    guard = 0;
    while (!model_idle() && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    repeat (4) @(negedge clk);
    chk("rand_drained", 32'(model_idle()), 32'h1);
    chk("rand_outputs_idle", 32'(bus.valid_op), 32'h0);
    chk("rand_drop_count", 32'(bus.drop_count), 32'(drop_exp));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
